// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;
  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 16;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last time wins.
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt
);
  always_comb begin
    case (req)
      2'b10:   gnt = REQ_DBG;
      2'b11:   gnt = ~last_grant;
      default: gnt = REQ_CPU;
    endcase
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU and debug accesses to the 256x16 data memory: grant, one
// access cycle, one response cycle; all memory pins and responses registered.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e              state_q, state_d;
  logic                gnt_q, gnt_d, last_q, last_d, arb_gnt;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  rr_arbiter2 u_arb (
    .req        ({m1_req, m0_req}),
    .last_grant (last_q),
    .gnt        (arb_gnt)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      IDLE: begin
        // Request fields are captured only here; later changes are ignored.
        if (m0_req || m1_req) begin
          gnt_d       = arb_gnt;
          mem_addr_d  = arb_gnt ? m1_addr  : m0_addr;
          mem_wdata_d = arb_gnt ? m1_wdata : m0_wdata;
          mem_write_d = arb_gnt ? m1_we    : m0_we;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (!mem_write_q) begin
          if (gnt_q) rdata1_d = mem_rdata;
          else       rdata0_d = mem_rdata;
        end
        state_d = RESP;
      end
      RESP: begin
        ack0_d  = (gnt_q == REQ_CPU);
        ack1_d  = (gnt_q == REQ_DBG);
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= REQ_CPU;
      last_q      <= REQ_DBG;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected acks and memory
// writes; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [7:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic        mem_write;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem [256];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic        id;
    logic        chk_rd;
    logic [15:0] rdata;
    int          exp_cyc;
  } ack_t;
  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  ack_t ack_q[$];
  wr_t  wr_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory model: synchronous write, combinational read.
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every ack and every write strobe cycle against the queues.
  always @(negedge clk) begin
    if (m0_ack && m1_ack) chk("ack_overlap", 1, 0);
    for (int r = 0; r < 2; r++) begin
      if ((r == 0) ? m0_ack : m1_ack) begin
        if (ack_q.size() == 0) chk("unexpected_ack", r, 32'hFFFF_FFFF);
        else begin
          ack_t e;
          e = ack_q.pop_front();
          chk("ack_id", r, {31'd0, e.id});
          chk("ack_cycle", cyc, e.exp_cyc);
          if (e.chk_rd) chk("ack_rdata", (r == 0) ? m0_rdata : m1_rdata, e.rdata);
        end
      end
    end
    if (mem_write) begin
      if (wr_q.size() == 0) chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_data", mem_wdata, w.data);
      end
    end
  end

  function automatic void exp_ack(input logic id, input logic chk_rd,
                                  input logic [15:0] rd, input int at);
    ack_t e;
    e.id = id; e.chk_rd = chk_rd; e.rdata = rd; e.exp_cyc = at;
    ack_q.push_back(e);
  endfunction

  function automatic void exp_wr(input logic [7:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endfunction

  // Called at a negedge; holds req until ack, optionally disturbing inputs mid-access.
  task automatic do_req(input bit id, input bit we, input logic [7:0] a,
                        input logic [15:0] d, input bit perturb);
    bit got = 0;
    if (id == 0) begin m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1; end
    else         begin m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1; end
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (perturb && n == 0) begin
        if (id == 0) begin m0_addr = a + 8'd1; m0_wdata = ~d; end
        else         begin m1_addr = a + 8'd1; m1_wdata = ~d; end
      end
      got = (id == 0) ? m0_ack : m1_ack;
    end
    if (id == 0) m0_req = 0; else m1_req = 0;
    if (!got) chk("ack_timeout", id, 32'hFFFF_FFFF);
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    rst = 1; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);

    // m0 writes 0xBEEF to 0x10, m1 reads it back
    t0 = cyc; exp_ack(0, 0, 0, t0 + 3); exp_wr(8'h10, 16'hBEEF);
    do_req(0, 1, 8'h10, 16'hBEEF, 0);
    t0 = cyc; exp_ack(1, 1, 16'hBEEF, t0 + 3);
    do_req(1, 0, 8'h10, 16'h0, 0);

    // Continuous contention: grants 0,1,0,1 spaced by 3 cycles
    t0 = cyc;
    exp_ack(0, 1, 16'hBEEF, t0 + 3);
    exp_ack(1, 0, 0, t0 + 6); exp_wr(8'h30, 16'h0A0A);
    exp_ack(0, 1, 16'h0A0A, t0 + 9);
    exp_ack(1, 1, 16'hBEEF, t0 + 12);
    fork
      begin do_req(0, 0, 8'h10, 0, 0); do_req(0, 0, 8'h30, 0, 0); end
      begin do_req(1, 1, 8'h30, 16'h0A0A, 0); do_req(1, 0, 8'h10, 0, 0); end
    join

    // Top address: m1 writes and reads 0xFF; m0_rdata keeps its last read
    t0 = cyc; exp_ack(1, 0, 0, t0 + 3); exp_wr(8'hFF, 16'h0001);
    do_req(1, 1, 8'hFF, 16'h0001, 0);
    t0 = cyc; exp_ack(1, 1, 16'h0001, t0 + 3);
    do_req(1, 0, 8'hFF, 0, 0);
    chk("m0_rdata_held", m0_rdata, 16'h0A0A);

    // Inputs changed during ACCESS must not reach the memory
    t0 = cyc; exp_ack(0, 0, 0, t0 + 3); exp_wr(8'h20, 16'h1234);
    do_req(0, 1, 8'h20, 16'h1234, 1);
    t0 = cyc; exp_ack(1, 1, 16'h1234, t0 + 3);
    do_req(1, 0, 8'h20, 0, 0);
    t0 = cyc; exp_ack(1, 1, 16'h0000, t0 + 3);
    do_req(1, 0, 8'h21, 0, 0);

    // Reset while an m0 write strobe is high: no ack, outputs cleared
    exp_wr(8'h40, 16'h7777);
    m0_we = 1; m0_addr = 8'h40; m0_wdata = 16'h7777; m0_req = 1;
    @(negedge clk);
    chk("abort_strobe_seen", mem_write, 1);
    rst = 1; m0_req = 0;
    @(negedge clk);
    rst = 0;
    chk("abort_mem_write", mem_write, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_m0_rdata", m0_rdata, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_ack", {m1_ack, m0_ack}, 0);
    end

    // Post-reset tie: m0 first, m1 three cycles later
    t0 = cyc;
    exp_ack(0, 1, 16'hBEEF, t0 + 3);
    exp_ack(1, 1, 16'h0001, t0 + 6);
    fork
      do_req(0, 0, 8'h10, 0, 0);
      do_req(1, 0, 8'hFF, 0, 0);
    join

    for (int i = 0; i < 20 && (ack_q.size() != 0 || wr_q.size() != 0); i++)
      @(negedge clk);
    chk("pending_acks", ack_q.size(), 0);
    chk("pending_writes", wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got cyc %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and access sequencer for the 256 x 16-bit data memory. Requester 0 is the CPU load/store stage; requester 1 is the debug/loader port. The block serialises accesses with round-robin priority and drives the memory's write, address and data_in pins from registers. It returns read data with a fixed, registered latency.

Parameters:
ADDR_W, 8, word address width (256 words)
DATA_W, 16, word width

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
m0_req  in  1  requester 0 access request; held high until m0_ack
m0_we  in  1  requester 0: 1 = write, 0 = read
m0_addr  in  ADDR_W  requester 0 word address
m0_wdata  in  DATA_W  requester 0 write data
m0_ack  out  1  one-cycle completion pulse to requester 0
m0_rdata  out  DATA_W  read data; valid when m0_ack is high
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as the m0_* ports, for requester 1
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data (combinational from mem_addr)

Behaviour:
- Reset: state=IDLE, last_grant=1 (requester 0 wins the first tie); mem_write, mem_addr, mem_wdata, m0_ack, m1_ack, m0_rdata, m1_rdata all 0.
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - No requests: stay in IDLE and drive all memory outputs as 0 / held.
  - Exactly one request: grant that requester.
  - Both requesting: grant the requester not in last_grant.
  - On grant: register gnt, mem_addr<=mX_addr, mem_wdata<=mX_wdata, mem_write<=mX_we, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_write is high for this cycle only, and only for writes.
  - For reads, capture mem_rdata into the granted mX_rdata register. For writes, mX_rdata is unchanged.
  - At the end of the cycle, mem_write<=0; go to RESP.
- RESP (1 cycle): the granted requester's mX_ack=1; last_grant<=gnt; go to IDLE.
- Latency and throughput:
  - A request first sampled at edge N produces ack high during the cycle after edge N+2.
  - Throughput is one access per 3 cycles.
- Handshake:
  - Address, we and wdata are sampled only at the grant edge. Changes afterwards are ignored for that transaction.
  - A requester keeps req high until ack. If req is still high during the ack cycle, it is a new request, evaluated in the next IDLE.
  - Dropping req before ack is a protocol violation. The transaction still completes and the ack is still issued.
- mX_rdata holds its value until the next read for that requester.
- The ungranted requester's ack stays 0 throughout.
- Fairness: under continuous requests from both, grants alternate 0,1,0,1. Neither requester waits more than one other transaction.
- Reset mid-operation: at the edge where rst=1, return to IDLE and zero all outputs. No ack is issued for the aborted transaction. A write strobe already high in ACCESS is cleared at that edge.
- Addresses use the full ADDR_W with no wrap logic; address 255 is legal.

Decomposition:
- The shared package holds:
  - the state enum (IDLE, ACCESS, RESP);
  - ADDR_W / DATA_W defaults;
  - the requester index constants REQ_CPU=0 and REQ_DBG=1.
- One natural sub-module, rr_arbiter2: a two-way round-robin grant decision from req[1:0] and last_grant, output gnt. It is combinational, with last_grant registered in the parent.

Test Plan:
- Write: m0 writes 0xBEEF to address 0x10; later m1 reads 0x10.
  - Required: mem_write high for exactly 1 cycle with mem_addr=0x10; m1_rdata=0xBEEF at m1_ack; m0_ack 3 cycles after the req edge.
- Simultaneous first requests after reset: m0 and m1 both request.
  - Required: m0 granted first; m1 acks 3 cycles after m0_ack.
- Continuous contention: both requesters hold req for 12 cycles.
  - Required: 4 acks, in order 0,1,0,1; no ack cycle overlap.
- Boundary address: m1 writes 0x0001 to address 0xFF, then reads it back.
  - Required: mem_addr=0xFF; read returns 0x0001; m0_rdata unchanged.
- Reset mid-write: rst asserted during ACCESS of an m0 write.
  - Required: next cycle mem_write=0, state IDLE, no m0_ack; a post-reset simultaneous request grants m0 first.
- Input stability: m0 changes m0_addr and m0_wdata during ACCESS.
  - Required: memory sees the values sampled at the grant edge only.
